// File: rtl/cache_fill_pkg.sv
// Shared types and default sizing for the cache fill arbiter.
// Addresses are byte addresses of 16-bit words, so a block spans 2*WORDS bytes.
package cache_fill_pkg;

  localparam int WORDS_DEF   = 8;
  localparam int MEM_LAT_DEF = 4;
  localparam logic [15:0] BLK_MASK = 16'(2 * WORDS_DEF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single main-memory port between I-fill, D-fill and D write-through,
// issuing a block fill as back-to-back pipelined reads and steering returned words.
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic                       d_req,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic                       d_wr,
  input  logic [ADDR_W-1:0]          d_wr_addr,
  input  logic [DATA_W-1:0]          d_wr_data,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_valid,
  output logic [DATA_W-1:0]          fill_data,
  output logic [$clog2(WORDS)-1:0]   fill_idx,
  output logic                       i_fill_we,
  output logic                       d_fill_we,
  output logic                       i_done,
  output logic                       d_done,
  output logic                       d_wr_done,
  output logic                       busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK_L = ADDR_W'(2 * WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_ISSUE = IDX_W'(WORDS - 1);
  localparam logic [IDX_W:0]    RX_FULL    = (IDX_W + 1)'(WORDS);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [IDX_W:0]      rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic                i_fill_we_q, i_fill_we_d;
  logic                d_fill_we_q, d_fill_we_d;
  logic                rx_take_s;

  // Next-state, counters and the receive-path register inputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    fill_data_d = fill_data_q;
    fill_idx_d  = fill_idx_q;
    i_fill_we_d = 1'b0;
    d_fill_we_d = 1'b0;

    // Returns beyond the block length are a protocol error and are dropped.
    rx_take_s = mem_valid && (state_q == ISSUE || state_q == DRAIN) && (rx_cnt_q < RX_FULL);

    if (rx_take_s) begin
      fill_data_d = mem_rdata;
      fill_idx_d  = rx_cnt_q[IDX_W-1:0];
      i_fill_we_d = (owner_q == OWN_I);
      d_fill_we_d = (owner_q == OWN_D);
      rx_cnt_d    = rx_cnt_q + (IDX_W + 1)'(1);
    end else begin
      rx_cnt_d    = rx_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (d_wr) begin
          state_d = WRITE;
          addr_d  = d_wr_addr;
          wdata_d = d_wr_data;
        end else if (d_req) begin
          state_d     = ISSUE;
          owner_d     = OWN_D;
          addr_d      = d_addr & ~BLK_MASK_L;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
        end else if (i_req) begin
          state_d     = ISSUE;
          owner_d     = OWN_I;
          addr_d      = i_addr & ~BLK_MASK_L;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: state_d = IDLE;
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + IDX_W'(1);
        if (issue_cnt_q == LAST_ISSUE) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (rx_cnt_q == RX_FULL) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered fill outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      addr_q      <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
      i_fill_we_q <= 1'b0;
      d_fill_we_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      fill_data_q <= fill_data_d;
      fill_idx_q  <= fill_idx_d;
      i_fill_we_q <= i_fill_we_d;
      d_fill_we_q <= d_fill_we_d;
    end
  end

  // The base is block aligned, so the word offset is ORed in and can never carry out.
  always_comb begin
    mem_en    = (state_q == ISSUE) || (state_q == WRITE);
    mem_wr    = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? wdata_q : '0;
    if (state_q == ISSUE) begin
      mem_addr = addr_q | ADDR_W'({issue_cnt_q, 1'b0});
    end else if (state_q == WRITE) begin
      mem_addr = addr_q;
    end else begin
      mem_addr = '0;
    end
  end

  assign fill_data = fill_data_q;
  assign fill_idx  = fill_idx_q;
  assign i_fill_we = i_fill_we_q;
  assign d_fill_we = d_fill_we_q;
  assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
  assign d_wr_done = (state_q == WRITE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory model
// and a scoreboard of expected read addresses and fill writes.
module tb_cache_fill_arbiter;
  import cache_fill_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0, d_wr_addr = '0;
  logic [DATA_W-1:0] d_wr_data = '0;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_valid = 1'b0;
  logic [DATA_W-1:0] fill_data;
  logic [2:0]        fill_idx;
  logic              i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .d_wr_done(d_wr_done), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fills_i = 0;
  int fills_d = 0;
  logic extra_valid = 1'b0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [20:0]       exp_fill_q[$];

  logic              pv[0:MEM_LAT-1] = '{default: 1'b0};
  logic [ADDR_W-1:0] pa[0:MEM_LAT-1] = '{default: 16'h0000};

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return mem_en && !mem_wr;
      1:       return i_done;
      2:       return d_done;
      3:       return d_wr_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_fill(input logic is_d, input logic [ADDR_W-1:0] base);
    for (int k = 0; k < WORDS; k++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(2 * k);
      exp_addr_q.push_back(a);
      exp_fill_q.push_back({is_d, ~is_d, 3'(k), mem_word(a)});
    end
  endtask

  task automatic wait_for(input int sel, input string tag, output int at);
    at = -1;
    for (int n = 0; n < 64 && at < 0; n++) begin
      @(negedge clk);
      if (sel_sig(sel)) at = cyc;
    end
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a read issued in cycle t returns in cycle t+MEM_LAT.
  always @(negedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    mem_valid <= pv[MEM_LAT-1] || extra_valid;
    mem_rdata <= pv[MEM_LAT-1] ? mem_word(pa[MEM_LAT-1]) : 16'h0000;
  end

  // Scoreboard: every read address and fill write is popped in order.
  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      if (exp_addr_q.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      else chk("rd_unexpected", 32'(mem_en), 32'd0);
    end
    if (i_fill_we || d_fill_we) begin
      if (i_fill_we) fills_i <= fills_i + 1;
      if (d_fill_we) fills_d <= fills_d + 1;
      if (exp_fill_q.size() > 0)
        chk("fill", 32'({d_fill_we, i_fill_we, fill_idx, fill_data}), 32'(exp_fill_q.pop_front()));
      else chk("fill_unexpected", 32'({i_fill_we, d_fill_we}), 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, fi0, fd0;

    #1;
    chk("rst_flags", 32'({mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_fill_data", 32'(fill_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single I fill, block-aligned from a mid-block address.
    push_fill(1'b0, 16'h0120);
    i_addr = 16'h0126; i_req = 1'b1;
    wait_for(0, "t1_issue", t0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_for(1, "t1_done", t1);
    chk("t1_latency", 32'(t1 - t0), 32'd13);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", 32'(i_done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_fills_i", 32'(fills_i), 32'd8);
    chk("t1_fills_d", 32'(fills_d), 32'd0);

    // Simultaneous D and I requests: D first, one idle cycle, then I.
    push_fill(1'b1, 16'h4000);
    push_fill(1'b0, 16'h0200);
    d_addr = 16'h4008; i_addr = 16'h020C;
    d_req = 1'b1; i_req = 1'b1;
    wait_for(2, "t2_d_done", t1);
    d_req = 1'b0;
    wait_for(0, "t2_i_issue", t0);
    chk("t2_gap", 32'(t0 - t1), 32'd2);
    wait_for(1, "t2_i_done", t1);
    i_req = 1'b0;

    // Write-through beats a pending I fill.
    push_fill(1'b0, 16'h0300);
    i_addr = 16'h0300; i_req = 1'b1;
    d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr = 1'b1;
    wait_for(3, "t3_wr_done", t1);
    chk("t3_wr_ctl", 32'({mem_en, mem_wr}), 32'd3);
    chk("t3_wr_addr", 32'(mem_addr), 32'h2002);
    chk("t3_wr_data", 32'(mem_wdata), 32'hBEEF);
    d_wr = 1'b0;
    wait_for(0, "t3_i_issue", t0);
    chk("t3_i_start", 32'(t0 - t1), 32'd2);
    wait_for(1, "t3_i_done", t1);
    i_req = 1'b0;

    // Top-of-memory block must not wrap.
    push_fill(1'b1, 16'hFFF0);
    d_addr = 16'hFFF8; d_req = 1'b1;
    wait_for(2, "t4_d_done", t1);
    d_req = 1'b0;
    @(negedge clk);

    // Reset in the fifth issue cycle of an I fill.
    push_fill(1'b0, 16'h0550);
    i_addr = 16'h0550; i_req = 1'b1;
    wait_for(0, "t5_issue", t0);
    repeat (4) @(negedge clk);
    fi0 = fills_i;
    #1;
    rst = 1'b1; i_req = 1'b0;
    exp_addr_q.delete();
    exp_fill_q.delete();
    #1;
    chk("t5_rst_flags", 32'({mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy}), 32'd0);
    chk("t5_rst_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_no_fill_after_rst", 32'(fills_i - fi0), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    fd0 = fills_d;
    push_fill(1'b1, 16'h1230);
    d_addr = 16'h1234; d_req = 1'b1;
    wait_for(2, "t5_d_done", t1);
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_d_fills", 32'(fills_d - fd0), 32'd8);

    // Request dropped after two issue cycles still completes.
    fi0 = fills_i;
    push_fill(1'b0, 16'h0A10);
    i_addr = 16'h0A1E; i_req = 1'b1;
    wait_for(0, "t6_issue", t0);
    @(negedge clk);
    i_req = 1'b0;
    wait_for(1, "t6_done", t1);
    chk("t6_latency", 32'(t1 - t0), 32'd13);
    @(negedge clk);
    chk("t6_fills_i", 32'(fills_i - fi0), 32'd8);

    // Stray mem_valid while idle is ignored.
    fi0 = fills_i; fd0 = fills_d;
    #1 extra_valid = 1'b1;
    @(negedge clk);
    #1 extra_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_stray_valid", 32'((fills_i - fi0) + (fills_d - fd0)), 32'd0);
    chk("t7_idle", 32'(busy), 32'd0);

    chk("queues_empty", 32'(exp_addr_q.size() + exp_fill_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
